// File: rtl/key_array_controller_pkg.sv
// rtl/key_array_controller_pkg.sv - shared state encoding and default intervals for the key array
package key_array_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } key_state_e;

  localparam int unsigned DEFAULT_NUM_KEYS        = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEFAULT_HOLD_INTERVAL   = 50000000;
  localparam int unsigned DEFAULT_REPEAT_INTERVAL = 1000000;
  localparam int unsigned DEFAULT_TIMER_WIDTH     = 32;

endpackage

// File: rtl/key_array_controller_key_channel.sv
// rtl/key_array_controller_key_channel.sv - one key: synchroniser, debouncer, press/hold/repeat FSM
module key_channel
  import key_array_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_INTERVAL   = DEFAULT_HOLD_INTERVAL,
  parameter int unsigned REPEAT_INTERVAL = DEFAULT_REPEAT_INTERVAL,
  parameter int unsigned TIMER_WIDTH     = DEFAULT_TIMER_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  input  logic repeat_en_i,
  output logic pressed_o,
  output logic released_o,
  output logic repeat_o,
  output logic down_o,
  output logic held_o
);

  logic                   sync1_q, sync2_q, stable_q;
  logic [TIMER_WIDTH-1:0] deb_q, hold_q, rep_q;
  key_state_e             state_q;
  logic                   pressed_q, released_q, repeat_q, down_q, held_q;
  logic                   level_differs, level_accept;

  assign level_differs = (sync2_q != stable_q);
  // The FSM reacts in the same edge the debouncer accepts, so the pulse lands with the level flip.
  assign level_accept  = level_differs && (deb_q == TIMER_WIDTH'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      deb_q    <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      if (!level_differs) begin
        deb_q <= '0;
      end else if (level_accept) begin
        deb_q    <= '0;
        stable_q <= sync2_q;
      end else begin
        deb_q <= deb_q + TIMER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      rep_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      repeat_q   <= 1'b0;
      down_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      repeat_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_accept && !sync2_q) begin
            pressed_q <= 1'b1;
            down_q    <= 1'b1;
            hold_q    <= '0;
            state_q   <= ST_PRESSED;
          end
        end
        ST_PRESSED, ST_REPEAT: begin
          // Outside IDLE an accepted level is always a release, and it beats any due repeat.
          if (level_accept) begin
            released_q <= 1'b1;
            down_q     <= 1'b0;
            held_q     <= 1'b0;
            hold_q     <= '0;
            rep_q      <= '0;
            state_q    <= ST_IDLE;
          end else if (state_q == ST_PRESSED) begin
            if (hold_q == TIMER_WIDTH'(HOLD_INTERVAL - 1)) begin
              held_q   <= 1'b1;
              rep_q    <= '0;
              repeat_q <= repeat_en_i;
              state_q  <= ST_REPEAT;
            end else begin
              hold_q <= hold_q + TIMER_WIDTH'(1);
            end
          end else if (!repeat_en_i) begin
            rep_q <= '0;
          end else if (rep_q == TIMER_WIDTH'(REPEAT_INTERVAL - 1)) begin
            repeat_q <= 1'b1;
            rep_q    <= '0;
          end else begin
            rep_q <= rep_q + TIMER_WIDTH'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pressed_o  = pressed_q;
  assign released_o = released_q;
  assign repeat_o   = repeat_q;
  assign down_o     = down_q;
  assign held_o     = held_q;

endmodule

// File: rtl/key_array_controller.sv
// rtl/key_array_controller.sv - array of independent key channels plus the combined event flag
module key_array_controller
  import key_array_controller_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_INTERVAL   = DEFAULT_HOLD_INTERVAL,
  parameter int unsigned REPEAT_INTERVAL = DEFAULT_REPEAT_INTERVAL,
  parameter int unsigned TIMER_WIDTH     = DEFAULT_TIMER_WIDTH
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_KEYS-1:0] repeat_enable,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_event
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_INTERVAL  (HOLD_INTERVAL),
      .REPEAT_INTERVAL(REPEAT_INTERVAL),
      .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_key_channel (
      .clk_i      (clock),
      .rst_ni     (resetn),
      .key_n_i    (KEY[g]),
      .repeat_en_i(repeat_enable[g]),
      .pressed_o  (key_pressed[g]),
      .released_o (key_released[g]),
      .repeat_o   (key_repeat[g]),
      .down_o     (key_down[g]),
      .held_o     (key_held[g])
    );
  end

  assign any_event = |{key_pressed, key_released, key_repeat};

endmodule

// File: tb/tb_key_array_controller.sv
// tb/tb_key_array_controller.sv - scoreboard bench with a timestamp-based reference model
module tb_key_array_controller;

  localparam int NK   = 4;
  localparam int D    = 4;
  localparam int H    = 20;
  localparam int R    = 5;
  localparam int TW   = 16;
  localparam int HIST = D + 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [NK-1:0] KEY = '1;
  logic [NK-1:0] repeat_enable = '0;
  logic [NK-1:0] key_pressed, key_released, key_repeat, key_down, key_held;
  logic          any_event;

  key_array_controller #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .HOLD_INTERVAL(H),
    .REPEAT_INTERVAL(R), .TIMER_WIDTH(TW)
  ) dut (
    .clock(clock), .resetn(resetn), .KEY(KEY), .repeat_enable(repeat_enable),
    .key_pressed(key_pressed), .key_released(key_released), .key_repeat(key_repeat),
    .key_down(key_down), .key_held(key_held), .any_event(any_event)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] rep;
    logic [NK-1:0] down;
    logic [NK-1:0] held;
    logic          any;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  bit   raw_h   [NK][HIST];
  bit   m_stable[NK];
  bit   m_down  [NK];
  bit   m_held  [NK];
  int   m_press [NK];
  int   m_anchor[NK];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  // Model: a level is accepted once D consecutive synchronised samples differ from the stable level;
  // repeats fall R edges after the latest anchor (hold expiry, previous pulse or a disabled edge).
  task automatic step(input logic [NK-1:0] key, input logic [NK-1:0] en, input logic rst_n);
    obs_t e;
    bit   flip;
    KEY = key;
    repeat_enable = en;
    resetn = rst_n;
    edge_n++;
    e = '0;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < HIST; i++) raw_h[k][i] = 1'b1;
        m_stable[k] = 1'b1;
        m_down[k]   = 1'b0;
        m_held[k]   = 1'b0;
      end else begin
        for (int i = HIST - 1; i > 0; i--) raw_h[k][i] = raw_h[k][i-1];
        raw_h[k][0] = key[k];
        flip = 1'b1;
        for (int j = 0; j < D; j++) if (raw_h[k][2+j] == m_stable[k]) flip = 1'b0;
        if (flip) begin
          m_stable[k] = !m_stable[k];
          m_down[k]   = !m_stable[k];
          m_held[k]   = 1'b0;
          if (m_down[k]) begin
            e.p[k] = 1'b1;
            m_press[k] = edge_n;
          end else begin
            e.r[k] = 1'b1;
          end
        end else if (m_down[k] && !m_held[k]) begin
          if (edge_n - m_press[k] == H) begin
            m_held[k]   = 1'b1;
            m_anchor[k] = edge_n;
            e.rep[k]    = en[k];
          end
        end else if (m_held[k]) begin
          if (!en[k] || (edge_n - m_anchor[k] == R)) begin
            e.rep[k]    = en[k];
            m_anchor[k] = edge_n;
          end
        end
      end
      e.down[k] = m_down[k];
      e.held[k] = m_held[k];
    end
    e.any = |{e.p, e.r, e.rep};
    exp_q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic monitor();
    obs_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {key_pressed, key_released, key_repeat, key_down, key_held, any_event};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs edge=%0d got=%h exp=%h", edge_n, a, e);
        end
      end
    end
  endtask

  initial begin
    int e0, seen, first, cnt, rel, idx;
    int dur[NK];
    logic [NK-1:0] rk, re;
    fork
      monitor();
    join_none

    @(negedge clock);
    #1;
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0, 1'b0);
    for (int i = 0; i < 100; i++) step(4'hF, 4'h0, 1'b1);

    e0 = edge_n + 1; seen = -1;
    for (int i = 0; i < 12; i++) begin
      step(4'hE, 4'h0, 1'b1);
      if (key_pressed[0] && seen < 0) seen = edge_n;
    end
    chk("press_latency", seen - e0, D + 1);
    for (int i = 0; i < 10; i++) step(4'hF, 4'h0, 1'b1);

    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(4'hD, 4'h0, 1'b1); cnt += int'(key_pressed[1]); end
    for (int i = 0; i < 2; i++) begin step(4'hF, 4'h0, 1'b1); cnt += int'(key_pressed[1]); end
    e0 = edge_n + 1; seen = -1;
    for (int i = 0; i < 12; i++) begin
      step(4'hD, 4'h0, 1'b1);
      cnt += int'(key_pressed[1]);
      if (key_pressed[1] && seen < 0) seen = edge_n;
    end
    chk("bounce_press_count", cnt, 1);
    chk("bounce_latency", seen - e0, D + 1);
    for (int i = 0; i < 10; i++) step(4'hF, 4'h0, 1'b1);

    seen = -1; first = -1; cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(4'hB, 4'hF, 1'b1);
      if (key_pressed[2]) seen = edge_n;
      if (key_repeat[2]) begin cnt++; if (first < 0) first = edge_n; end
    end
    chk("hold_first_repeat", first - seen, H);
    chk("hold_repeat_count", cnt, 7);
    chk("hold_held_level", int'(key_held[2]), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(4'hF, 4'hF, 1'b1); cnt += int'(key_released[2]); end
    chk("hold_release_count", cnt, 1);
    chk("hold_held_cleared", int'(key_held[2]), 0);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(4'h7, 4'h7, 1'b1); cnt += int'(key_repeat[3]); end
    chk("gated_no_repeat", cnt, 0);
    chk("gated_held", int'(key_held[3]), 1);
    e0 = edge_n + 1; first = -1; rel = -1; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step((i < 4) ? 4'h7 : 4'hF, 4'hF, 1'b1);
      if (key_repeat[3]) begin cnt++; if (first < 0) first = edge_n; end
      if (key_released[3]) rel = edge_n;
    end
    chk("reenable_first_repeat", first - e0, R - 1);
    chk("collide_repeat_count", cnt, 1);
    chk("collide_release_edge", rel - e0, 2 * R - 1);

    for (int i = 0; i < 35; i++) step(4'hB, 4'hF, 1'b1);
    chk("pre_reset_held", int'(key_held[2]), 1);
    resetn = 1'b0;
    #1;
    chk("async_reset_clear",
        int'({key_pressed, key_released, key_repeat, key_down, key_held, any_event}), 0);
    rel = 0;
    for (int i = 0; i < 3; i++) begin step(4'hB, 4'hF, 1'b0); rel += int'(key_released[2]); end
    e0 = edge_n + 1; seen = -1;
    for (int i = 0; i < 10; i++) begin
      step(4'hB, 4'hF, 1'b1);
      rel += int'(key_released[2]);
      if (key_pressed[2] && seen < 0) seen = edge_n;
    end
    chk("reset_repress_latency", seen - e0, D + 1);
    chk("reset_no_release", rel, 0);
    for (int i = 0; i < 10; i++) step(4'hF, 4'hF, 1'b1);

    rk = '1; re = '1;
    for (int k = 0; k < NK; k++) dur[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          rk[k] = ~rk[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : int'($urandom_range(5, 70));
        end else begin
          dur[k]--;
        end
      end
      if ($urandom_range(0, 29) == 0) begin
        idx = int'($urandom_range(0, NK - 1));
        re[idx] = ~re[idx];
      end
      step(rk, re, ($urandom_range(0, 799) != 0));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
